// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter that shares one uart_send transmitter
//                among N_REQ frame sources. Each source posts a frame of up
//                to MAX_BYTES bytes with a one-cycle start pulse. The granted
//                frame is fed out one byte at a time over the
//                uart_en / uart_tx_busy handshake.
//  Ports       : sys_clk, sys_rst_n  - clock, asynchronous active-low reset
//                start[N_REQ]        - per-source frame request pulse
//                msg_len, msg_data   - per-source length and frame bytes
//                done[N_REQ]         - frame finished / aborted pulse
//                pending[N_REQ]      - queued-request flags
//                grant[N_REQ]        - one-hot transmitter owner, 0 when idle
//                arb_busy            - arbiter not in IDLE
//                err_timeout         - busy never rose after a send strobe
//                uart_en, uart_din   - send strobe and byte to uart_send
//                uart_tx_busy        - busy flag from uart_send
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MAX_BYTES = 8,
    parameter int LEN_W     = 4,
    parameter int BUSY_TO   = 16
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [N_REQ-1:0]             start,
    input  logic [N_REQ*LEN_W-1:0]       msg_len,
    input  logic [N_REQ*MAX_BYTES*8-1:0] msg_data,
    output logic [N_REQ-1:0]             done,
    output logic [N_REQ-1:0]             pending,
    output logic [N_REQ-1:0]             grant,
    output logic                         arb_busy,
    output logic                         err_timeout,
    output logic                         uart_en,
    output logic [7:0]                   uart_din,
    input  logic                         uart_tx_busy
);

    localparam int c_src_w  = $clog2(N_REQ);
    localparam int c_byte_w = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int c_to_w   = $clog2(BUSY_TO + 1);

    localparam logic [LEN_W-1:0]   c_max_len  = LEN_W'(MAX_BYTES);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(BUSY_TO - 1);
    localparam logic [c_src_w-1:0] c_last_src = c_src_w'(N_REQ - 1);
    localparam logic [c_src_w-1:0] c_src_one  = c_src_w'(1);
    localparam logic [N_REQ-1:0]   c_oh_one   = N_REQ'(1);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_load     = 3'd1;
    localparam logic [2:0] c_st_wait_rdy = 3'd2;
    localparam logic [2:0] c_st_send     = 3'd3;
    localparam logic [2:0] c_st_wait_hi  = 3'd4;
    localparam logic [2:0] c_st_wait_lo  = 3'd5;
    localparam logic [2:0] c_st_done     = 3'd6;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [N_REQ-1:0]       r_pending;
    logic [N_REQ-1:0]       r_grant;
    logic [c_src_w-1:0]     r_gidx;
    logic [c_src_w-1:0]     r_rr_ptr;
    logic [MAX_BYTES*8-1:0] r_frame;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_idx;
    logic [c_to_w-1:0]      r_to_cnt;
    logic                   r_abort;
    logic [7:0]             r_din;

    logic                   w_found;
    logic [c_src_w-1:0]     w_pick;
    logic [c_src_w-1:0]     w_cand;
    logic [c_src_w-1:0]     w_rr_nxt;
    logic [N_REQ-1:0]       w_pick_oh;
    logic [LEN_W-1:0]       w_len_raw;
    logic [LEN_W-1:0]       w_len_eff;
    logic [LEN_W-1:0]       w_idx_next;
    logic                   w_timeout;
    logic [N_REQ-1:0]       w_done;
    logic                   w_err;
    logic                   w_en;
    logic                   w_busy;

    // Per-source views of the flattened request buses.
    logic [LEN_W-1:0]       w_src_len  [N_REQ];
    logic [MAX_BYTES*8-1:0] w_src_data [N_REQ];
    logic [7:0]             w_frame_byte [MAX_BYTES];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_src
        assign w_src_len[gi]  = msg_len[gi*LEN_W +: LEN_W];
        assign w_src_data[gi] = msg_data[gi*MAX_BYTES*8 +: MAX_BYTES*8];
    end

    for (genvar gb = 0; gb < MAX_BYTES; gb++) begin : g_byte
        assign w_frame_byte[gb] = r_frame[gb*8 +: 8];
    end

    // Round-robin search: first pending source at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        w_cand  = r_rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && r_pending[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
            w_cand = (w_cand == c_last_src) ? '0 : w_cand + c_src_one;
        end
    end

    assign w_rr_nxt   = (w_pick == c_last_src) ? '0 : w_pick + c_src_one;
    assign w_pick_oh  = c_oh_one << w_pick;
    assign w_len_raw  = w_src_len[r_gidx];
    assign w_len_eff  = (w_len_raw > c_max_len) ? c_max_len : w_len_raw;
    assign w_idx_next = r_idx + LEN_W'(1);

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_done      = '0;
        w_err       = 1'b0;
        w_en        = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            c_st_idle: begin
                w_busy = 1'b0;
                if (|r_pending) begin
                    w_state_nxt = c_st_load;
                end
            end
            c_st_load: begin
                w_state_nxt = (w_len_eff == '0) ? c_st_done : c_st_wait_rdy;
            end
            c_st_wait_rdy: begin
                if (!uart_tx_busy) begin
                    w_state_nxt = c_st_send;
                end
            end
            c_st_send: begin
                w_en        = 1'b1;
                w_state_nxt = c_st_wait_hi;
            end
            c_st_wait_hi: begin
                if (uart_tx_busy) begin
                    w_state_nxt = c_st_wait_lo;
                end else if (r_to_cnt == c_to_last) begin
                    w_state_nxt = c_st_done;
                    w_timeout   = 1'b1;
                end
            end
            c_st_wait_lo: begin
                if (!uart_tx_busy) begin
                    w_state_nxt = (w_idx_next == r_len) ? c_st_done : c_st_wait_rdy;
                end
            end
            c_st_done: begin
                w_done      = r_grant;
                w_err       = r_abort;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Frame datapath, grant and round-robin pointer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_frame  <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_to_cnt <= '0;
            r_abort  <= 1'b0;
            r_din    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_gidx   <= w_pick;
                        r_grant  <= w_pick_oh;
                        r_rr_ptr <= w_rr_nxt;
                    end
                end
                c_st_load: begin
                    // Frame is captured here only; later changes on the
                    // request bus cannot disturb the frame in flight.
                    r_frame <= w_src_data[r_gidx];
                    r_len   <= w_len_eff;
                    r_idx   <= '0;
                    r_abort <= 1'b0;
                end
                c_st_wait_rdy: begin
                    if (!uart_tx_busy) begin
                        r_din <= w_frame_byte[r_idx[c_byte_w-1:0]];
                    end
                end
                c_st_send: begin
                    r_to_cnt <= '0;
                end
                c_st_wait_hi: begin
                    if (w_timeout) begin
                        r_abort <= 1'b1;
                    end else if (!uart_tx_busy) begin
                        r_to_cnt <= r_to_cnt + c_to_w'(1);
                    end
                end
                c_st_wait_lo: begin
                    if (!uart_tx_busy) begin
                        r_idx <= w_idx_next;
                    end
                end
                c_st_done: begin
                    r_grant <= '0;
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    // A start that coincides with the clear of the same source wins, so a
    // source restarting in its own done cycle is queued again.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= start | (r_pending & ~w_done);
        end
    end

    assign done        = w_done;
    assign pending     = r_pending;
    assign grant       = r_grant;
    assign arb_busy    = w_busy;
    assign err_timeout = w_err;
    assign uart_en     = w_en;
    assign uart_din    = r_din;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter with a uart_send
//                busy model, a table of frame vectors and hand-written
//                sequences for timing, fairness, timeout and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N_REQ     = 2;
    localparam int MAX_BYTES = 8;
    localparam int LEN_W     = 4;
    localparam int BUSY_TO   = 16;

    logic                         sys_clk = 1'b0;
    logic                         sys_rst_n = 1'b0;
    logic [N_REQ-1:0]             start = '0;
    logic [N_REQ*LEN_W-1:0]       msg_len = '0;
    logic [N_REQ*MAX_BYTES*8-1:0] msg_data = '0;
    logic [N_REQ-1:0]             done;
    logic [N_REQ-1:0]             pending;
    logic [N_REQ-1:0]             grant;
    logic                         arb_busy;
    logic                         err_timeout;
    logic                         uart_en;
    logic [7:0]                   uart_din;
    logic                         uart_tx_busy;

    uart_tx_arbiter #(
        .N_REQ     (N_REQ),
        .MAX_BYTES (MAX_BYTES),
        .LEN_W     (LEN_W),
        .BUSY_TO   (BUSY_TO)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .msg_len      (msg_len),
        .msg_data     (msg_data),
        .done         (done),
        .pending      (pending),
        .grant        (grant),
        .arb_busy     (arb_busy),
        .err_timeout  (err_timeout),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .uart_tx_busy (uart_tx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int start_cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // uart_send model: busy for 10 cycles after each strobe, or never.
    int busy_cnt = 0;
    bit never_busy = 1'b0;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                   busy_cnt <= 0;
        else if (uart_en && !never_busy)  busy_cnt <= 10;
        else if (busy_cnt > 0)            busy_cnt <= busy_cnt - 1;
    end
    assign uart_tx_busy = (busy_cnt != 0);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Event capture.
    logic [7:0]       en_q[$];
    logic [N_REQ-1:0] en_grant_q[$];
    int               en_cyc_q[$];
    int               done_src_q[$];
    int               done_cyc_q[$];
    int               err_cyc_q[$];

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (uart_en) begin
                en_q.push_back(uart_din);
                en_grant_q.push_back(grant);
                en_cyc_q.push_back(cyc);
                chk("en_while_busy", {127'd0, uart_tx_busy}, 128'd0);
            end
            for (int i = 0; i < N_REQ; i++)
                if (done[i]) begin
                    done_src_q.push_back(i);
                    done_cyc_q.push_back(cyc);
                end
            if (err_timeout) err_cyc_q.push_back(cyc);
        end
    end

    function automatic int src_of(input logic [N_REQ-1:0] g);
        if (g == 2'b01) return 0;
        if (g == 2'b10) return 1;
        return 9;
    endfunction

    task automatic clear_q();
        en_q.delete(); en_grant_q.delete(); en_cyc_q.delete();
        done_src_q.delete(); done_cyc_q.delete(); err_cyc_q.delete();
    endtask

    task automatic pulse_start(input logic [N_REQ-1:0] mask);
        @(negedge sys_clk);
        start = mask;
        start_cyc = cyc;
        @(negedge sys_clk);
        start = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !(!arb_busy && pending == '0)) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= budget) chk("idle_wait_expired", 128'd1, 128'd0);
        @(negedge sys_clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (cycles) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    function automatic logic [127:0] outs_now();
        return {97'd0, done, pending, grant, arb_busy, err_timeout, uart_en, uart_din};
    endfunction

    typedef struct {
        logic [1:0]   start;
        logic [3:0]   len0;
        logic [3:0]   len1;
        logic [63:0]  d0;
        logic [63:0]  d1;
        int           n_bytes;
        logic [127:0] exp_bytes;
        logic [15:0]  exp_bsrc;
        int           n_done;
        logic [1:0]   exp_dsrc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          order_n;
        logic [3:0]  order;
        int          n;

        // Round-robin pointer is 0 after each reset; vectors are ordered so
        // the expected service order follows from that.
        vecs[0] = '{start:2'b11, len0:4'd2, len1:4'd2, d0:64'hA2A1, d1:64'hB2B1,
                    n_bytes:4, exp_bytes:128'hB2B1A2A1, exp_bsrc:16'b1100,
                    n_done:2, exp_dsrc:2'b10};
        vecs[1] = '{start:2'b11, len0:4'd1, len1:4'd1, d0:64'h55, d1:64'h66,
                    n_bytes:2, exp_bytes:128'h6655, exp_bsrc:16'b10,
                    n_done:2, exp_dsrc:2'b10};
        vecs[2] = '{start:2'b01, len0:4'd3, len1:4'd0, d0:64'h333231, d1:64'h0,
                    n_bytes:3, exp_bytes:128'h333231, exp_bsrc:16'b0,
                    n_done:1, exp_dsrc:2'b00};
        vecs[3] = '{start:2'b10, len0:4'd0, len1:4'd12, d0:64'h0, d1:64'h0807060504030201,
                    n_bytes:8, exp_bytes:128'h0807060504030201, exp_bsrc:16'hFF,
                    n_done:1, exp_dsrc:2'b01};
        vecs[4] = '{start:2'b11, len0:4'd0, len1:4'd1, d0:64'hFF, d1:64'h77,
                    n_bytes:1, exp_bytes:128'h77, exp_bsrc:16'b1,
                    n_done:2, exp_dsrc:2'b10};

        // Reset state.
        repeat (3) @(negedge sys_clk);
        chk("reset_outputs", outs_now(), 128'd0);
        sys_rst_n = 1'b1;

        // Single frame timing from reset.
        clear_q();
        msg_len  = {4'd0, 4'd3};
        msg_data = {64'h0, 64'h333231};
        pulse_start(2'b01);
        wait_idle(500);
        chk("t1_en_latency", (en_cyc_q.size() > 0) ? en_cyc_q[0] - start_cyc : -1, 128'd4);
        chk("t1_grant_at_en", (en_grant_q.size() > 0) ? en_grant_q[0] : 2'b00, 128'b01);
        chk("t1_bytes", {en_q.size() == 3 ? {en_q[2], en_q[1], en_q[0]} : 24'h0}, 128'h333231);
        chk("t1_done_count", done_src_q.size(), 128'd1);
        chk("t1_grant_idle", grant, 128'd0);

        // Table-driven frames from a fresh reset.
        do_reset(2);
        for (int v = 0; v < 5; v++) begin
            clear_q();
            msg_len  = {vecs[v].len1, vecs[v].len0};
            msg_data = {vecs[v].d1, vecs[v].d0};
            pulse_start(vecs[v].start);
            wait_idle(2000);
            chk($sformatf("v%0d_nbytes", v), en_q.size(), vecs[v].n_bytes);
            for (int k = 0; k < vecs[v].n_bytes; k++)
                if (k < en_q.size()) begin
                    chk($sformatf("v%0d_byte%0d", v, k), en_q[k], vecs[v].exp_bytes[k*8 +: 8]);
                    chk($sformatf("v%0d_src%0d", v, k), src_of(en_grant_q[k]), vecs[v].exp_bsrc[k]);
                end
            chk($sformatf("v%0d_ndone", v), done_src_q.size(), vecs[v].n_done);
            for (int k = 0; k < vecs[v].n_done; k++)
                if (k < done_src_q.size())
                    chk($sformatf("v%0d_done%0d_src", v, k), done_src_q[k], vecs[v].exp_dsrc[k]);
            chk($sformatf("v%0d_no_err", v), err_cyc_q.size(), 128'd0);
            if (v == 0 && en_cyc_q.size() > 2 && done_cyc_q.size() > 0)
                chk("t2_handover_gap", en_cyc_q[2] - done_cyc_q[0], 128'd4);
        end

        // Zero-length frame: done three cycles after start, no strobe.
        clear_q();
        msg_len = {4'd0, 4'd0};
        pulse_start(2'b01);
        wait_idle(200);
        chk("len0_done_latency", (done_cyc_q.size() > 0) ? done_cyc_q[0] - start_cyc : -1, 128'd3);
        chk("len0_no_en", en_q.size(), 128'd0);

        // Busy never rises: both frames abort; source 1 is next in rotation.
        clear_q();
        never_busy = 1'b1;
        msg_len  = {4'd1, 4'd2};
        msg_data = {64'hC1, 64'hD2D1};
        pulse_start(2'b11);
        wait_idle(500);
        never_busy = 1'b0;
        chk("to_err_count", err_cyc_q.size(), 128'd2);
        chk("to_en_count", en_q.size(), 128'd2);
        if (err_cyc_q.size() > 0 && en_cyc_q.size() > 0 && done_cyc_q.size() > 0) begin
            chk("to_err_latency", err_cyc_q[0] - en_cyc_q[0], BUSY_TO + 1);
            chk("to_err_with_done", done_cyc_q[0], err_cyc_q[0]);
        end else begin
            chk("to_events_present", 128'd0, 128'd1);
        end
        chk("to_done_order", {(done_src_q.size() > 1) ? done_src_q[1] : 9,
                              (done_src_q.size() > 0) ? done_src_q[0] : 9}, {32'd0, 32'd1});

        // Fairness: both sources restart in their own done cycle.
        clear_q();
        msg_len  = {4'd1, 4'd1};
        msg_data = {64'hE1, 64'hF1};
        @(negedge sys_clk);
        start = 2'b10;
        order_n = 0;
        order = '0;
        @(negedge sys_clk);
        start = 2'b01;
        for (int c = 0; c < 400 && order_n < 4; c++) begin
            @(negedge sys_clk);
            start = '0;
            if (done != '0) begin
                order[order_n] = done[1];
                order_n++;
                start = done;
            end
        end
        @(negedge sys_clk);
        start = '0;
        wait_idle(500);
        chk("rr_frames_seen", order_n, 128'd4);
        chk("rr_alternation", order, 128'b0101);

        // Reset mid-frame, after the second byte has been strobed.
        clear_q();
        msg_len  = {4'd0, 4'd3};
        msg_data = {64'h0, 64'h333231};
        pulse_start(2'b01);
        n = 0;
        while (en_q.size() < 2 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        chk("rst_two_bytes_sent", en_q.size() >= 2, 128'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", outs_now(), 128'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_q();
        repeat (30) @(negedge sys_clk);
        chk("rst_no_stale_en", en_q.size(), 128'd0);
        chk("rst_no_done", done_src_q.size(), 128'd0);
        msg_len  = {4'd1, 4'd0};
        msg_data = {64'h99, 64'h0};
        pulse_start(2'b10);
        wait_idle(300);
        chk("rst_new_byte", (en_q.size() == 1) ? en_q[0] : 8'h00, 128'h99);
        chk("rst_new_done", (done_src_q.size() == 1) ? done_src_q[0] : 9, 128'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
